// File: rtl/bram_row_gather.sv
// bram_row_gather: loads one N-element row from a BRAM read port starting at
// a caller-supplied base address and presents it as a parallel row with a
// one-cycle done strobe for the softmax core.

// One row element: holds its value until the capture path selects it.
module bram_row_gather_lane #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [BIT_WIDTH-1:0] i_d,
  output logic [BIT_WIDTH-1:0] o_q
);

  // Element register, cleared by reset, written only on its capture slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_q <= '0;
    else if (i_we) o_q <= i_d;
  end

endmodule

module bram_row_gather #(
  parameter int N            = 32,
  parameter int BIT_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_row_base,
  output logic                          o_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_rd_addr,
  input  logic [BIT_WIDTH-1:0]          i_rd_data,
  output logic [N-1:0][BIT_WIDTH-1:0]   o_row,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state, state_nx;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [CW-1:0]              iss_cnt;
  logic [CW-1:0]              cap_cnt;
  logic [READ_LATENCY-1:0]    vld_pipe;
  logic                       cap_vld;
  logic                       cap_done;
  logic                       start_acc;

  // A start is only honoured from IDLE; anything else is dropped.
  assign start_acc = (state == IDLE) && i_start;
  assign cap_vld   = vld_pipe[READ_LATENCY-1];
  // Last capture lands this cycle, or all captures already landed.
  assign cap_done  = (cap_cnt == CW'(N)) || (cap_vld && (cap_cnt == CW'(N-1)));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_start) state_nx = ISSUE;
      ISSUE:   if (iss_cnt == CW'(N-1)) state_nx = DRAIN;
      DRAIN:   if (cap_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state; address is zero outside ISSUE.
  always_comb begin
    o_rd_en   = (state == ISSUE);
    o_busy    = (state != IDLE);
    o_done    = (state == DONE);
    o_rd_addr = o_rd_en ? base_q + ADDR_WIDTH'(iss_cnt) : '0;
  end

  // Base latch plus issue/capture counters; capture counts whenever data returns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q  <= '0;
      iss_cnt <= '0;
      cap_cnt <= '0;
    end else if (start_acc) begin
      base_q  <= i_row_base;
      iss_cnt <= '0;
      cap_cnt <= '0;
    end else begin
      if (state == ISSUE) iss_cnt <= iss_cnt + 1'b1;
      if (cap_vld)        cap_cnt <= cap_cnt + 1'b1;
    end
  end

  // Read-valid delay line matching the BRAM latency.
  generate
    if (READ_LATENCY == 1) begin : g_vld_l1
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vld_pipe <= '0;
        else       vld_pipe <= o_rd_en;
      end
    end else begin : g_vld_ln
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[READ_LATENCY-2:0], o_rd_en};
      end
    end
  endgenerate

  // Per-element storage; element k is written on the k-th returned word.
  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      bram_row_gather_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (cap_vld && (cap_cnt == CW'(k))),
        .i_d   (i_rd_data),
        .o_q   (o_row[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bram_row_gather.sv
// tb_bram_row_gather: two instances (read latency 1 and 2) driven in lockstep
// against a BRAM model; rows, address streams and done timing are compared
// with values computed directly from the row-gather rules.
module tb_bram_row_gather;

  localparam int N   = 32;
  localparam int BW  = 16;
  localparam int AW  = 10;
  localparam int WIN = 80;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start [2];
  logic [AW-1:0]         base  [2];
  logic                  rd_en [2];
  logic [AW-1:0]         rd_addr [2];
  logic [N-1:0][BW-1:0]  row   [2];
  logic                  busy  [2];
  logic                  done  [2];

  logic [BW-1:0]         mem [0:1023];
  logic [BW-1:0]         p1 [2];
  logic [BW-1:0]         p2 [2];

  int lat [2] = '{1, 2};
  int cyc = 0;
  int t0  = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  // read / done logs
  logic [AW-1:0]         ra [2][0:255];
  int                    rc [2][0:255];
  int                    nr [2];
  int                    dc [2][0:7];
  logic [N-1:0][BW-1:0]  drow [2][0:7];
  int                    nd [2];
  logic [N-1:0][BW-1:0]  rowlog [2][0:127];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_row_gather #(.N(N), .BIT_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_row_base(base[0]),
    .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(p1[0]),
    .o_row(row[0]), .o_busy(busy[0]), .o_done(done[0]));

  bram_row_gather #(.N(N), .BIT_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_row_base(base[1]),
    .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(p2[1]),
    .o_row(row[1]), .o_busy(busy[1]), .o_done(done[1]));

  // BRAM models: registered read, second stage for latency 2
  always @(posedge clk) begin
    if (rd_en[0]) p1[0] <= mem[rd_addr[0]];
    if (rd_en[1]) p1[1] <= mem[rd_addr[1]];
    p2[1] <= p1[1];
  end

  // Monitor: sample on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i] && nr[i] < 256) begin
        ra[i][nr[i]] = rd_addr[i];
        rc[i][nr[i]] = cyc;
        nr[i] = nr[i] + 1;
      end
      if (done[i] && nd[i] < 8) begin
        dc[i][nd[i]]   = cyc;
        drow[i][nd[i]] = row[i];
        nd[i] = nd[i] + 1;
      end
      if ((cyc - t0) >= 0 && (cyc - t0) < 128) rowlog[i][cyc - t0] = row[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] ref_elem(input int b, input int k);
    return mem[(b + k) % 1024];
  endfunction

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      nr[i] = 0;
      nd[i] = 0;
    end
  endtask

  // One load (optionally followed by a back-to-back load, or with spurious
  // starts at cycles 5/33/34) on both instances, then check against the model.
  task automatic run(input int b1, input int b2, input bit b2b, input bit spur);
    bit s;
    int nl, tb, bb, lim;
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b1;
      base[i]  = AW'(b1);
    end
    @(posedge clk);
    #1 t0 = cyc - 1;
    for (int j = 1; j <= WIN; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s = 1'b0;
        base[i] = AW'($urandom);
        if (spur && (j == 5 || j == 33 || j == 34)) begin
          s = 1'b1;
          base[i] = AW'(200);
        end
        if (b2b && j == N + lat[i] + 2) begin
          s = 1'b1;
          base[i] = AW'(b2);
        end
        start[i] = s;
      end
    end
    for (int i = 0; i < 2; i++) start[i] = 1'b0;

    nl = b2b ? 2 : 1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("L%0d_nreads", lat[i]), nr[i], nl * N);
      lim = (nr[i] < nl * N) ? nr[i] : nl * N;
      for (int x = 0; x < lim; x++) begin
        tb = t0 + (x / N) * (N + lat[i] + 2);
        bb = (x / N == 0) ? b1 : b2;
        check($sformatf("L%0d_addr%0d", lat[i], x), 32'(ra[i][x]), (bb + x % N) % 1024);
        check($sformatf("L%0d_rdcyc%0d", lat[i], x), rc[i][x], tb + 1 + x % N);
      end
      check($sformatf("L%0d_ndone", lat[i]), nd[i], nl);
      lim = (nd[i] < nl) ? nd[i] : nl;
      for (int m = 0; m < lim; m++) begin
        tb = t0 + m * (N + lat[i] + 2);
        bb = (m == 0) ? b1 : b2;
        check($sformatf("L%0d_donecyc%0d", lat[i], m), dc[i][m], tb + N + lat[i] + 1);
        for (int k = 0; k < N; k++)
          check($sformatf("L%0d_row%0d_e%0d", lat[i], m, k), 32'(drow[i][m][k]), 32'(ref_elem(bb, k)));
      end
      if (spur) begin
        s = 1'b0;
        for (int x = 0; x < nr[i]; x++) if (ra[i][x] == AW'(200)) s = 1'b1;
        check($sformatf("L%0d_no_addr200", lat[i]), 32'(s), 0);
      end
      if (b2b) begin
        // row 0 held from its done until row 1's first capture becomes visible
        for (int r = N + lat[i] + 1; r <= 2 * lat[i] + N + 3; r++)
          for (int k = 0; k < N; k += 7)
            check($sformatf("L%0d_hold_c%0d_e%0d", lat[i], r, k), 32'(rowlog[i][r][k]), 32'(ref_elem(b1, k)));
        check($sformatf("L%0d_first_cap", lat[i]), 32'(rowlog[i][2 * lat[i] + N + 4][0]), 32'(ref_elem(b2, 0)));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_L%0d_rd_en", tag, lat[i]), 32'(rd_en[i]), 0);
      check($sformatf("%s_L%0d_rd_addr", tag, lat[i]), 32'(rd_addr[i]), 0);
      check($sformatf("%s_L%0d_row", tag, lat[i]), 32'(|row[i]), 0);
      check($sformatf("%s_L%0d_busy", tag, lat[i]), 32'(busy[i]), 0);
      check($sformatf("%s_L%0d_done", tag, lat[i]), 32'(done[i]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      base[i]  = '0;
    end
    clear_logs();
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a * 3 - 40);

    // reset state
    #1 rst = 1'b1;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic load, base 0, linear memory
    run(0, 0, 1'b0, 1'b0);
    check("L1_row0_signed", 32'($signed(drow[0][0][0])), 32'(-40));
    check("L1_row31", 32'(drow[0][0][31]), 32'(16'(53)));

    // random memory, row offset 64
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    run(64, 0, 1'b0, 1'b0);
    check("L2_row31_mem95", 32'(drow[1][0][31]), 32'(mem[95]));

    // address wrap
    run(1010, 0, 1'b0, 1'b0);
    check("L1_wrap_e14", 32'(drow[0][0][14]), 32'(mem[0]));
    check("L1_wrap_e31", 32'(drow[0][0][31]), 32'(mem[17]));

    // starts while busy are ignored
    run(300, 0, 1'b0, 1'b1);

    // reset mid-load
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b1;
      base[i]  = AW'(100);
    end
    @(posedge clk);
    #1 t0 = cyc - 1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) start[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (50) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst_L%0d_nodone", lat[i]), nd[i], 0);
      check($sformatf("midrst_L%0d_noreads", lat[i]), nr[i], 0);
    end
    run(int'($urandom_range(0, 1023)), 0, 1'b0, 1'b0);

    // back-to-back rows
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    run(0, 32, 1'b1, 1'b0);
    check("L1_b2b_period", dc[0][1] - dc[0][0], 35);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
